// File: rtl/util_pkg.sv
// Shared definitions for the utility blocks: debounce FSM state encoding and
// the effective stability-threshold rule.
package util_pkg;

    localparam logic UTIL_DEB_STABLE = 1'b0;
    localparam logic UTIL_DEB_CHECK  = 1'b1;

    typedef enum logic {
        DEB_STABLE = UTIL_DEB_STABLE,
        DEB_CHECK  = UTIL_DEB_CHECK
    } deb_state_e;

    // A threshold of zero behaves exactly like one: accept on the first differing sample.
    function automatic logic [31:0] deb_limit(input logic [31:0] limit);
        return (limit == 32'd0) ? 32'd1 : limit;
    endfunction

endpackage

// File: rtl/util_debounce_ch.sv
// One debounce channel: STABLE/CHECK FSM, stability counter, registered level,
// busy flag and (with UTIL_DEBOUNCE_EDGE_EN) rise/fall pulse registers.
module util_debounce_ch
    import util_pkg::*;
#(
    parameter int   CNT_W   = 16,
    parameter logic RST_VAL = 1'b0
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             sync_i,
    input  logic [CNT_W-1:0] limit_i,
    output logic             data_o,
    output logic             rise_o,
    output logic             fall_o,
    output logic             busy_o
);

    deb_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             data_q, data_d;
    logic             busy_q, busy_d;
    logic [31:0]      eff_lim;
    logic             differ;
    logic             lim_hit;

    assign eff_lim = deb_limit(32'(limit_i));
    assign differ  = (sync_i != data_q);
    // 33-bit compare so cnt+1 can never wrap, even at the maximum threshold.
    assign lim_hit = ((33'(cnt_q) + 33'd1) >= 33'(eff_lim));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        unique case (state_q)
            DEB_STABLE: begin
                if (differ) begin
                    if (eff_lim == 32'd1) begin
                        data_d = sync_i;
                    end else begin
                        state_d = DEB_CHECK;
                        cnt_d   = CNT_W'(1);
                    end
                end
            end
            DEB_CHECK: begin
                if (!differ) begin
                    state_d = DEB_STABLE;
                    cnt_d   = '0;
                end else if (lim_hit) begin
                    data_d  = sync_i;
                    state_d = DEB_STABLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = DEB_STABLE;
                cnt_d   = '0;
            end
        endcase
        // Busy covers the checking cycles plus the cycle that resolves the check.
        busy_d = (state_q == DEB_CHECK) || (state_d == DEB_CHECK);
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= DEB_STABLE;
            cnt_q   <= '0;
            data_q  <= RST_VAL;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
        end
    end

`ifdef UTIL_DEBOUNCE_EDGE_EN
    logic rise_q, fall_q;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            rise_q <= data_d & ~data_q;
            fall_q <= ~data_d & data_q;
        end
    end

    assign rise_o = rise_q;
    assign fall_o = fall_q;
`else
    assign rise_o = 1'b0;
    assign fall_o = 1'b0;
`endif

    assign data_o = data_q;
    assign busy_o = busy_q;

endmodule

// File: rtl/util_debounce.sv
// Multi-channel debounce and edge detector after a two-flop synchronizer.
// Define UTIL_DEBOUNCE_EDGE_EN to build the rise_o/fall_o pulse registers.
module util_debounce
    import util_pkg::*;
#(
    parameter int               WIDTH     = 1,
    parameter int               CNT_W     = 16,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic [WIDTH-1:0] sync_i,
    input  logic [CNT_W-1:0] limit_i,
    output logic [WIDTH-1:0] data_o,
    output logic [WIDTH-1:0] rise_o,
    output logic [WIDTH-1:0] fall_o,
    output logic [WIDTH-1:0] busy_o
);

    for (genvar g = 0; g < WIDTH; g++) begin : g_ch
        util_debounce_ch #(
            .CNT_W   (CNT_W),
            .RST_VAL (RESET_VAL[g])
        ) u_ch (
            .clk_i   (clk_i),
            .reset_i (reset_i),
            .sync_i  (sync_i[g]),
            .limit_i (limit_i),
            .data_o  (data_o[g]),
            .rise_o  (rise_o[g]),
            .fall_o  (fall_o[g]),
            .busy_o  (busy_o[g])
        );
    end

endmodule

// File: tb/tb_util_debounce.sv
// Directed bench for util_debounce: 4 channels, RESET_VAL=4'b1010, edge
// expectations follow whether UTIL_DEBOUNCE_EDGE_EN is defined.
module tb_util_debounce;

    localparam int WIDTH = 4;
    localparam int CNT_W = 16;
    localparam logic [WIDTH-1:0] RVAL = 4'b1010;
`ifdef UTIL_DEBOUNCE_EDGE_EN
    localparam logic [WIDTH-1:0] EDGE_MASK = 4'b1111;
`else
    localparam logic [WIDTH-1:0] EDGE_MASK = 4'b0000;
`endif

    logic             clk_i = 1'b0;
    logic             reset_i;
    logic [WIDTH-1:0] sync_i;
    logic [CNT_W-1:0] limit_i;
    logic [WIDTH-1:0] data_o, rise_o, fall_o, busy_o;

    int checks   = 0;
    int failures = 0;

    util_debounce #(
        .WIDTH     (WIDTH),
        .CNT_W     (CNT_W),
        .RESET_VAL (RVAL)
    ) dut (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .sync_i  (sync_i),
        .limit_i (limit_i),
        .data_o  (data_o),
        .rise_o  (rise_o),
        .fall_o  (fall_o),
        .busy_o  (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [WIDTH-1:0] d, input logic [WIDTH-1:0] r,
                           input logic [WIDTH-1:0] f, input logic [WIDTH-1:0] b);
        chk({tag, ".data"}, data_o, d);
        chk({tag, ".rise"}, rise_o, r & EDGE_MASK);
        chk({tag, ".fall"}, fall_o, f & EDGE_MASK);
        chk({tag, ".busy"}, busy_o, b);
    endtask

    initial begin
        reset_i = 1'b1;
        sync_i  = RVAL;
        limit_i = 16'd4;
        #3;
        chk_all("reset", 4'b1010, 4'b0000, 4'b0000, 4'b0000);
        tick();
        tick();
        reset_i = 1'b0;
        tick();
        chk_all("idle", 4'b1010, 4'b0000, 4'b0000, 4'b0000);

        // clean rise on ch0, N=4
        sync_i = 4'b1011;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_all("clean_wait", 4'b1010, 4'b0000, 4'b0000, 4'b0001);
        end
        tick();
        chk_all("clean_accept", 4'b1011, 4'b0001, 4'b0000, 4'b0001);
        tick();
        chk_all("clean_after", 4'b1011, 4'b0000, 4'b0000, 4'b0000);

        // glitch of 3 cycles on ch0, N=4
        sync_i = 4'b1010;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_all("glitch_wait", 4'b1011, 4'b0000, 4'b0000, 4'b0001);
        end
        sync_i = 4'b1011;
        tick();
        chk_all("glitch_reject", 4'b1011, 4'b0000, 4'b0000, 4'b0001);
        tick();
        chk_all("glitch_idle", 4'b1011, 4'b0000, 4'b0000, 4'b0000);

        // limit 0 and 1: one-cycle acceptance
        limit_i = 16'd0;
        sync_i = 4'b1010;
        tick();
        chk_all("lim0_fall", 4'b1010, 4'b0000, 4'b0001, 4'b0000);
        sync_i = 4'b1011;
        tick();
        chk_all("lim0_rise", 4'b1011, 4'b0001, 4'b0000, 4'b0000);
        limit_i = 16'd1;
        sync_i = 4'b1010;
        tick();
        chk_all("lim1_fall", 4'b1010, 4'b0000, 4'b0001, 4'b0000);
        sync_i = 4'b1011;
        tick();
        chk_all("lim1_rise", 4'b1011, 4'b0001, 4'b0000, 4'b0000);
        tick();
        chk_all("lim1_idle", 4'b1011, 4'b0000, 4'b0000, 4'b0000);

        // limit lowered mid-check
        limit_i = 16'd100;
        sync_i = 4'b1010;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk_all("lower_wait", 4'b1011, 4'b0000, 4'b0000, 4'b0001);
        end
        limit_i = 16'd5;
        tick();
        chk_all("lower_accept", 4'b1010, 4'b0000, 4'b0001, 4'b0001);
        tick();
        chk_all("lower_idle", 4'b1010, 4'b0000, 4'b0000, 4'b0000);

        // all channels flip together, N=3
        limit_i = 16'd3;
        sync_i = 4'b0101;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk_all("multi_wait", 4'b1010, 4'b0000, 4'b0000, 4'b1111);
        end
        tick();
        chk_all("multi_accept", 4'b0101, 4'b0101, 4'b1010, 4'b1111);
        tick();
        chk_all("multi_idle", 4'b0101, 4'b0000, 4'b0000, 4'b0000);

        // reset mid-check aborts without pulses
        sync_i = 4'b1010;
        tick();
        chk_all("abort_wait", 4'b0101, 4'b0000, 4'b0000, 4'b1111);
        tick();
        reset_i = 1'b1;
        #1;
        chk_all("abort_reset", 4'b1010, 4'b0000, 4'b0000, 4'b0000);
        tick();
        chk_all("abort_hold", 4'b1010, 4'b0000, 4'b0000, 4'b0000);

        // differing level after reset release is debounced normally
        sync_i = 4'b0101;
        tick();
        reset_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk_all("post_wait", 4'b1010, 4'b0000, 4'b0000, 4'b1111);
        end
        tick();
        chk_all("post_accept", 4'b0101, 4'b0101, 4'b1010, 4'b1111);
        tick();
        chk_all("post_idle", 4'b0101, 4'b0000, 4'b0000, 4'b0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
